// File: rtl/timer_counter.sv
// Count engine of the APB timer: clock prescaler plus a CNT_W-bit up/down counter with wrap
// triggers. Optional pending flags and a sticky irq are built only when TIMER_IRQ_EN is defined.
module timer_counter #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned PRE_W = 4
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic             en,
  input  logic             load,
  input  logic             updown,
  input  logic [1:0]       cks,
  input  logic [CNT_W-1:0] tdr,
  input  logic [1:0]       clr_trig,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf_trig,
  output logic             udf_trig,
  output logic             irq
);

  typedef enum logic [1:0] {
    StStop = 2'b00,
    StLoad = 2'b01,
    StRun  = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PRE_W-1:0]   div_cnt_q, div_cnt_d;
  logic [1:0]         cks_q, cks_d;
  logic               ovf_trig_q, ovf_trig_d;
  logic               udf_trig_q, udf_trig_d;
  logic [PRE_W-1:0]   tick_mask;
  logic               cks_chg;
  logic               tick;

  // Load and enable are decoded from the live inputs; the datapath acts on that decode so a
  // load lands in cnt one cycle after it is requested.
  always_comb begin
    state_d = StStop;
    if (load) begin
      state_d = StLoad;
    end else if (en) begin
      state_d = StRun;
    end
  end

  // Low cks+1 bits of div_cnt all ones marks the end of a 2^(cks+1) prescale period.
  always_comb begin
    tick_mask = '0;
    unique case (cks)
      2'd0:    tick_mask[3:0] = 4'b0001;
      2'd1:    tick_mask[3:0] = 4'b0011;
      2'd2:    tick_mask[3:0] = 4'b0111;
      default: tick_mask[3:0] = 4'b1111;
    endcase
  end

  assign cks_chg = (cks != cks_q);
  assign tick    = (state_d == StRun) && !cks_chg && ((div_cnt_q & tick_mask) == tick_mask);
  assign cks_d   = cks;

  always_comb begin
    div_cnt_d = div_cnt_q;
    unique case (state_d)
      StLoad:  div_cnt_d = '0;
      StRun:   div_cnt_d = cks_chg ? '0 : div_cnt_q + PRE_W'(1);
      default: div_cnt_d = div_cnt_q;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    ovf_trig_d = 1'b0;
    udf_trig_d = 1'b0;
    if (state_d == StLoad) begin
      cnt_d = tdr;
    end else if (tick) begin
      if (updown) begin
        cnt_d      = cnt_q - CNT_W'(1);
        udf_trig_d = (cnt_q == '0);
      end else begin
        cnt_d      = cnt_q + CNT_W'(1);
        ovf_trig_d = &cnt_q;
      end
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q    <= StStop;
      cnt_q      <= '0;
      div_cnt_q  <= '0;
      cks_q      <= 2'b00;
      ovf_trig_q <= 1'b0;
      udf_trig_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_cnt_q  <= div_cnt_d;
      cks_q      <= cks_d;
      ovf_trig_q <= ovf_trig_d;
      udf_trig_q <= udf_trig_d;
    end
  end

  // The registered state is kept for observability; nothing downstream consumes it.
  logic unused_state;
  assign unused_state = ^state_q;

  assign cnt      = cnt_q;
  assign ovf_trig = ovf_trig_q;
  assign udf_trig = udf_trig_q;

`ifdef TIMER_IRQ_EN
  logic ovf_p_q, ovf_p_d;
  logic udf_p_q, udf_p_d;
  logic irq_q, irq_d;

  // A trigger arriving in the same cycle as its clear wins, so no wrap is ever lost.
  always_comb begin
    ovf_p_d = ovf_trig_q | (ovf_p_q & ~clr_trig[0]);
    udf_p_d = udf_trig_q | (udf_p_q & ~clr_trig[1]);
    irq_d   = ovf_p_d | udf_p_d;
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      ovf_p_q <= 1'b0;
      udf_p_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      ovf_p_q <= ovf_p_d;
      udf_p_q <= udf_p_d;
      irq_q   <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  logic unused_clr;
  assign unused_clr = ^clr_trig;
  assign irq        = 1'b0;
`endif

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter: a cycle model queues expected outputs as stimulus is
// driven, and each entry is popped and compared just after the following pclk edge.
module tb_timer_counter;

  localparam int unsigned CNT_W = 32;
  localparam int unsigned PRE_W = 4;

  logic             pclk = 1'b0;
  logic             preset = 1'b1;
  logic             en = 1'b0;
  logic             load = 1'b0;
  logic             updown = 1'b0;
  logic [1:0]       cks = 2'b00;
  logic [CNT_W-1:0] tdr = '0;
  logic [1:0]       clr_trig = 2'b00;
  logic [CNT_W-1:0] cnt;
  logic             ovf_trig;
  logic             udf_trig;
  logic             irq;

  timer_counter #(
    .CNT_W(CNT_W),
    .PRE_W(PRE_W)
  ) u_dut (
    .pclk    (pclk),
    .preset  (preset),
    .en      (en),
    .load    (load),
    .updown  (updown),
    .cks     (cks),
    .tdr     (tdr),
    .clr_trig(clr_trig),
    .cnt     (cnt),
    .ovf_trig(ovf_trig),
    .udf_trig(udf_trig),
    .irq     (irq)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [31:0] cnt;
    logic        ovf;
    logic        udf;
    logic        irq;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   ovf_seen = 0;
  int   udf_seen = 0;

  // Model state, always equal to what the DUT should show after the last edge.
  logic [31:0] m_cnt;
  int          m_div;
  logic [1:0]  m_cksq;
  logic        m_ovf, m_udf, m_ovfp, m_udfp, m_irq;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int   period;
    logic t_ovf, t_udf, n_ovfp, n_udfp;
    if (preset) begin
      m_cnt = '0; m_div = 0; m_cksq = 2'b00;
      m_ovf = 0; m_udf = 0; m_ovfp = 0; m_udfp = 0; m_irq = 0;
    end else begin
      t_ovf  = 1'b0;
      t_udf  = 1'b0;
      n_ovfp = m_ovf || (m_ovfp && !clr_trig[0]);
      n_udfp = m_udf || (m_udfp && !clr_trig[1]);
      if (load) begin
        m_cnt = tdr;
        m_div = 0;
      end else if (en) begin
        period = 2 << cks;
        if (cks != m_cksq) begin
          m_div = 0;
        end else begin
          if ((m_div % period) == period - 1) begin
            if (!updown) begin
              t_ovf = (m_cnt == 32'hFFFF_FFFF);
              m_cnt = m_cnt + 32'd1;
            end else begin
              t_udf = (m_cnt == 32'h0);
              m_cnt = m_cnt - 32'd1;
            end
          end
          m_div = (m_div + 1) % (1 << PRE_W);
        end
      end
      m_cksq = cks;
      m_ovf  = t_ovf;
      m_udf  = t_udf;
      m_ovfp = n_ovfp;
      m_udfp = n_udfp;
`ifdef TIMER_IRQ_EN
      m_irq  = n_ovfp || n_udfp;
`else
      m_irq  = 1'b0;
`endif
    end
  endtask

  task automatic cycle();
    exp_t e;
    model_step();
    e.cnt = m_cnt; e.ovf = m_ovf; e.udf = m_udf; e.irq = m_irq;
    sb_q.push_back(e);
    @(posedge pclk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_eq("cnt", cnt, e.cnt);
      check_eq("ovf_trig", {31'd0, ovf_trig}, {31'd0, e.ovf});
      check_eq("udf_trig", {31'd0, udf_trig}, {31'd0, e.udf});
      check_eq("irq", {31'd0, irq}, {31'd0, e.irq});
    end
    if (ovf_trig) ovf_seen++;
    if (udf_trig) udf_seen++;
  endtask

  initial begin
    // Reset values while preset is held.
    #12;
    check_eq("rst_cnt", cnt, 32'h0);
    check_eq("rst_trig", {30'd0, ovf_trig, udf_trig}, 32'd0);
    check_eq("rst_irq", {31'd0, irq}, 32'd0);
    cycle();
    preset = 1'b0;
    repeat (2) cycle();

    // T1: load then count up at /2.
    load = 1'b1; tdr = 32'h0000_00F0;
    cycle();
    check_eq("t1_load", cnt, 32'h0000_00F0);
    load = 1'b0; en = 1'b1; updown = 1'b0; cks = 2'd0;
    repeat (8) cycle();

    // T2: up-count wrap at /4, exactly one ovf pulse.
    load = 1'b1; tdr = 32'hFFFF_FFFE; cks = 2'd1;
    cycle();
    load = 1'b0; ovf_seen = 0;
    repeat (12) cycle();
    check_eq("t2_ovf_pulses", ovf_seen, 32'd1);

    // T3: down-count wrap at /16, exactly one udf pulse.
    load = 1'b1; tdr = 32'h1; updown = 1'b1; cks = 2'd3;
    cycle();
    load = 1'b0; udf_seen = 0;
    repeat (16) cycle();
    check_eq("t3_zero", cnt, 32'h0);
    repeat (20) cycle();
    check_eq("t3_udf_pulses", udf_seen, 32'd1);

    // T4: pause mid-prescale, then change cks during RUN.
    load = 1'b1; tdr = 32'h100; updown = 1'b0; cks = 2'd1;
    cycle();
    load = 1'b0;
    repeat (5) cycle();
    en = 1'b0;
    repeat (3) cycle();
    en = 1'b1;
    repeat (6) cycle();
    cks = 2'd2;
    repeat (12) cycle();

    // T5: clear pending, then clear in the same cycle as a fresh ovf (set wins).
    en = 1'b0; clr_trig = 2'b11;
    cycle();
    clr_trig = 2'b00;
    cycle();
    load = 1'b1; tdr = 32'hFFFF_FFFF; cks = 2'd0; en = 1'b1;
    cycle();
    load = 1'b0;
    repeat (3) cycle();
    load = 1'b1;
    cycle();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      clr_trig = {1'b0, m_ovf};
      cycle();
    end
    clr_trig = 2'b00;
    repeat (2) cycle();
    clr_trig = 2'b01;
    cycle();
    clr_trig = 2'b00;
    repeat (2) cycle();

    // Randomised mix, biased towards wrap values.
    for (int i = 0; i < 150; i++) begin
      load     = ($urandom_range(0, 15) == 0);
      en       = ($urandom_range(0, 7) != 0);
      updown   = ($urandom_range(0, 31) == 0) ? ~updown : updown;
      cks      = ($urandom_range(0, 31) == 0) ? 2'($urandom_range(0, 3)) : cks;
      clr_trig = 2'($urandom_range(0, 3));
      tdr      = $urandom_range(0, 1) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                      : 32'($urandom_range(0, 3));
      cycle();
    end

    // T6: asynchronous reset mid-count at 0x1234.
    load = 1'b1; tdr = 32'h0000_1230; cks = 2'd0; updown = 1'b0; en = 1'b1; clr_trig = 2'b00;
    cycle();
    load = 1'b0;
    for (int i = 0; i < 20 && m_cnt != 32'h1234; i++) cycle();
    check_eq("t6_pre", cnt, 32'h0000_1234);
    #2 preset = 1'b1;
    #1;
    check_eq("t6_cnt", cnt, 32'h0);
    check_eq("t6_trig", {30'd0, ovf_trig, udf_trig}, 32'd0);
    check_eq("t6_irq", {31'd0, irq}, 32'd0);
    cycle();
    en = 1'b0;
    preset = 1'b0;
    repeat (3) cycle();
    check_eq("t6_stop", cnt, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
